expr_eval: RTL and testbench
============================

# expr_eval

Streaming recogniser and evaluator for decimal arithmetic expressions of the form `num (op num)*`, where `op` is ASCII `+` or `*`. It consumes one ASCII character per qualified clock and flags whether the prefix seen so far is a complete, legal expression. It also computes that expression's value with `*` binding tighter than `+`. It is the parametrised successor to the single-digit P1 string checker: it adds multi-digit operands, a valid qualifier, a synchronous restart, a sticky error flag and an overflow flag. It sits behind the character source in the P1 test harness.

## Interface

- `W`, 32: width of `result` and of all internal accumulators; W ≥ 4.
- `MAX_DIGITS`, 4: maximum decimal digits per operand, leading zeros included; MAX_DIGITS ≥ 1.

- `clk`  in  1: clock; all state changes on rising edge.
- `clr_n`  in  1: one clock; reset is asynchronous and active-low.
- `restart`  in  1: synchronous restart to the empty-expression state.
- `in_valid`  in  1: `in` is sampled only when high.
- `in`  in  8: ASCII character.
- `out`  out  1: registered; high when the accepted prefix is a legal expression ending in a digit.
- `err`  out  1: registered, sticky; the prefix can never become legal.
- `result`  out  W: registered value of the expression up to the last accepted digit, modulo 2^W.
- `ovf`  out  1: registered, sticky; some intermediate value exceeded 2^W−1.

## Operation

- Internal registers:
  - `sum` (W bits): total of completed terms.
  - `prod` (W bits): product of completed factors in the current term.
  - `num` (W bits): the current operand.
  - `cnt` (0..MAX_DIGITS): digits in the current operand.
  - `state`.
- Reset and restart values: `sum`=0, `prod`=1, `num`=0, `cnt`=0, state S_START, `out`=0, `err`=0, `ovf`=0, `result`=0.
- Digit class is `in` in `"0"`..`"9"`, with d = `in`−8'h30. Operator class is `in` equal to `"+"` or `"*"`. Every other code is invalid.
- States and transitions, evaluated only when `in_valid`=1:
  - S_START:
    - digit → S_NUM; `num`=d, `cnt`=1.
    - anything else → S_ERR.
  - S_NUM, on digit with `cnt`<MAX_DIGITS: stay; `num`=`num`·10+d; `cnt`+1.
  - S_NUM, on digit with `cnt`=MAX_DIGITS: → S_ERR.
  - S_NUM, on `*`: → S_OP; `prod`=`prod`·`num`; `num`=0; `cnt`=0.
  - S_NUM, on `+`: → S_OP; `sum`=`sum`+`prod`·`num`; `prod`=1; `num`=0; `cnt`=0.
  - S_NUM, on invalid: → S_ERR.
  - S_OP:
    - digit → S_NUM; `num`=d, `cnt`=1.
    - anything else → S_ERR.
  - S_ERR: absorbing. Leave only via `clr_n` low or `restart`.
- Output updates on every accepted character:
  - `out` = 1 iff the next state is S_NUM.
  - `err` = 1 iff the next state is S_ERR.
  - On entering or staying in S_NUM, `result` = (`sum` + `prod`·`num_next`) mod 2^W, using next-state `num`.
  - Otherwise `result` holds.
- Arithmetic:
  - All operations are unsigned and truncated to W bits.
  - Each multiply and add is computed at full width: 2W for products, W+1 for sums.
  - `ovf` sets if any truncated bit is nonzero in `num`·10+d, `prod`·`num`, `sum`+term, or the `result` sum.
  - `ovf` has no effect on `out` or `err`.
- `in_valid`=0: all registers hold; `in` is ignored.
- `restart`=1: all state returns to the reset values on the next edge and any concurrent character is discarded. This holds in every state, S_ERR included.

## Timing

- Latency: 1 clock. Outputs reflect characters accepted up to and including the previous rising edge.
- `clr_n` low forces all reset values immediately, without waiting for `clk`.
- `clr_n` deassertion is synchronised upstream. The first edge with `clr_n` high may accept a character.
- Back-to-back characters are accepted on every cycle. There is no backpressure.
- Multiply and add paths are single-cycle combinational.

## Test plan

- Reset, W=8: feed `12+3*4` with `in_valid` held high.
  - `out` = 1,1,0,1,0,1.
  - `result` = 1,12,12,15,15,24.
  - `err`=0, `ovf`=0.
- `in_valid` gaps: feed `3*4*5` with `in_valid` low on alternate cycles.
  - Outputs change only on valid cycles.
  - Final `out`=1, `result`=60.
- Illegal sequences, with `err` sticky and `out`=0 afterwards:
  - `1++2`: `err` rises after the second `+`; the trailing `2` changes nothing.
  - Leading `*`: `err` rises immediately.
  - `7a`: `err` rises on `a`.
- Digit limit, MAX_DIGITS=4: `1234` gives `out`=1, `result`=1234 (W=16). A further `5` sets `err`=1.
- Overflow, W=8: `20*13` gives `result`=4, `ovf`=1 and `out`=1. A following `+1` gives `result`=5 with `ovf` still 1.
- Restart and reset:
  - Mid-expression `restart` with a concurrent `9`: outputs go to reset values and the `9` is dropped.
  - `clr_n` pulsed low between edges: outputs clear asynchronously before the next `clk`.

Source files
------------

// File: rtl/expr_eval.sv
// Streaming recogniser/evaluator for "num (op num)*" with op in {+,*}.
// One ASCII character per valid cycle; '*' binds tighter than '+'.
module expr_eval #(
  parameter int W          = 32,
  parameter int MAX_DIGITS = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         restart,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         out,
  output logic         err,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_START, S_NUM, S_OP, S_ERR} state_t;

  state_t          state;
  logic [W-1:0]    sum;
  logic [W-1:0]    prod;
  logic [W-1:0]    num;
  logic [CW-1:0]   cnt;

  logic            is_digit;
  logic            is_mul;
  logic            is_add;
  logic [W-1:0]    d_ext;
  logic [2*W-1:0]  mac_full;
  logic [W-1:0]    num_next;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  mul_full;
  logic [W:0]      add_full;
  logic            mac_ovf;
  logic            mul_ovf;
  logic            add_ovf;

  // The single multiplier serves both the running result (prod*num_next on a
  // digit) and term closure (prod*num on an operator); the adder likewise.
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_mul   = (in == 8'h2A);
    is_add   = (in == 8'h2B);
    d_ext    = W'(in[3:0]);
    mac_full = {{W{1'b0}}, num} * (2*W)'(10) + (2*W)'(in[3:0]);
    num_next = (state == S_NUM) ? mac_full[W-1:0] : d_ext;
    mul_b    = is_digit ? num_next : num;
    mul_full = {{W{1'b0}}, prod} * {{W{1'b0}}, mul_b};
    add_full = {1'b0, sum} + {1'b0, mul_full[W-1:0]};
    mac_ovf  = |mac_full[2*W-1:W];
    mul_ovf  = |mul_full[2*W-1:W];
    add_ovf  = add_full[W];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= S_START;
      sum    <= '0;
      prod   <= W'(1);
      num    <= '0;
      cnt    <= '0;
      out    <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else if (restart) begin
      state  <= S_START;
      sum    <= '0;
      prod   <= W'(1);
      num    <= '0;
      cnt    <= '0;
      out    <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else if (in_valid) begin
      case (state)
        S_START, S_OP: begin
          if (is_digit) begin
            state  <= S_NUM;
            num    <= d_ext;
            cnt    <= CW'(1);
            out    <= 1'b1;
            err    <= 1'b0;
            result <= add_full[W-1:0];
            ovf    <= ovf | mul_ovf | add_ovf;
          end else begin
            state <= S_ERR;
            out   <= 1'b0;
            err   <= 1'b1;
          end
        end
        S_NUM: begin
          if (is_digit && (cnt != CW'(MAX_DIGITS))) begin
            num    <= mac_full[W-1:0];
            cnt    <= cnt + CW'(1);
            out    <= 1'b1;
            err    <= 1'b0;
            result <= add_full[W-1:0];
            ovf    <= ovf | mac_ovf | mul_ovf | add_ovf;
          end else if (is_mul) begin
            state <= S_OP;
            prod  <= mul_full[W-1:0];
            num   <= '0;
            cnt   <= '0;
            out   <= 1'b0;
            err   <= 1'b0;
            ovf   <= ovf | mul_ovf;
          end else if (is_add) begin
            state <= S_OP;
            sum   <= add_full[W-1:0];
            prod  <= W'(1);
            num   <= '0;
            cnt   <= '0;
            out   <= 1'b0;
            err   <= 1'b0;
            ovf   <= ovf | mul_ovf | add_ovf;
          end else begin
            // Too many digits or an invalid code: the prefix is dead.
            state <= S_ERR;
            out   <= 1'b0;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= S_ERR;
          out   <= 1'b0;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a W=8 instance for most checks and a W=16
// instance for the four-digit operand limit, both driven by the same inputs.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;

  logic        out8, err8, ovf8;
  logic [7:0]  result8;
  logic        out16, err16, ovf16;
  logic [15:0] result16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  expr_eval #(.W(8), .MAX_DIGITS(4)) dut8 (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
    .out(out8), .err(err8), .result(result8), .ovf(ovf8)
  );

  expr_eval #(.W(16), .MAX_DIGITS(4)) dut16 (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
    .out(out16), .err(err16), .result(result16), .ovf(ovf16)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic [7:0] c, input logic v, input logic r);
    @(negedge clk);
    in_ch    = c;
    in_valid = v;
    restart  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doRestart();
    applyStimulus(8'h00, 1'b0, 1'b1);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, 1'b0);
  endtask

  initial begin
    string s1;
    int    exp_out1 [6];
    int    exp_res1 [6];
    string s2;
    int    exp_res2 [5];

    s1 = "12+3*4";
    exp_out1 = '{1, 1, 0, 1, 0, 1};
    exp_res1 = '{1, 12, 12, 15, 15, 24};
    s2 = "3*4*5";
    exp_res2 = '{3, 3, 12, 12, 60};

    #3;
    checkOutput("reset_out", int'(out8), 0);
    checkOutput("reset_err", int'(err8), 0);
    checkOutput("reset_result", int'(result8), 0);
    checkOutput("reset_ovf", int'(ovf8), 0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(s1[i], 1'b1, 1'b0);
      checkOutput($sformatf("expr1_out[%0d]", i), int'(out8), exp_out1[i]);
      checkOutput($sformatf("expr1_result[%0d]", i), int'(result8), exp_res1[i]);
    end
    checkOutput("expr1_err", int'(err8), 0);
    checkOutput("expr1_ovf", int'(ovf8), 0);

    doRestart();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s2[i], 1'b1, 1'b0);
      checkOutput($sformatf("gap_result[%0d]", i), int'(result8), exp_res2[i]);
      checkOutput($sformatf("gap_out[%0d]", i), int'(out8), (i % 2 == 0) ? 1 : 0);
      applyStimulus("a", 1'b0, 1'b0);
      checkOutput($sformatf("gap_hold_result[%0d]", i), int'(result8), exp_res2[i]);
      checkOutput($sformatf("gap_hold_err[%0d]", i), int'(err8), 0);
    end
    checkOutput("gap_final_out", int'(out8), 1);

    doRestart();
    feed("1+");
    checkOutput("plusplus_pre_err", int'(err8), 0);
    feed("+");
    checkOutput("plusplus_err", int'(err8), 1);
    checkOutput("plusplus_out", int'(out8), 0);
    feed("2");
    checkOutput("plusplus_sticky_err", int'(err8), 1);
    checkOutput("plusplus_sticky_out", int'(out8), 0);
    checkOutput("plusplus_result", int'(result8), 1);

    doRestart();
    feed("*");
    checkOutput("lead_star_err", int'(err8), 1);
    checkOutput("lead_star_out", int'(out8), 0);

    doRestart();
    feed("7");
    checkOutput("7a_pre_err", int'(err8), 0);
    checkOutput("7a_pre_out", int'(out8), 1);
    feed("a");
    checkOutput("7a_err", int'(err8), 1);
    checkOutput("7a_out", int'(out8), 0);
    checkOutput("7a_result", int'(result8), 7);

    doRestart();
    feed("1234");
    checkOutput("limit_out", int'(out16), 1);
    checkOutput("limit_result", int'(result16), 1234);
    checkOutput("limit_err", int'(err16), 0);
    feed("5");
    checkOutput("limit_over_err", int'(err16), 1);
    checkOutput("limit_over_out", int'(out16), 0);

    doRestart();
    feed("20*1");
    checkOutput("ovf_pre_result", int'(result8), 20);
    checkOutput("ovf_pre_ovf", int'(ovf8), 0);
    feed("3");
    checkOutput("ovf_result", int'(result8), 4);
    checkOutput("ovf_flag", int'(ovf8), 1);
    checkOutput("ovf_out", int'(out8), 1);
    feed("+1");
    checkOutput("ovf_plus_result", int'(result8), 5);
    checkOutput("ovf_plus_flag", int'(ovf8), 1);
    checkOutput("ovf_plus_err", int'(err8), 0);

    doRestart();
    feed("2*4");
    checkOutput("rst_pre_result", int'(result8), 8);
    applyStimulus("9", 1'b1, 1'b1);
    checkOutput("restart_out", int'(out8), 0);
    checkOutput("restart_result", int'(result8), 0);
    checkOutput("restart_err", int'(err8), 0);
    applyStimulus("3", 1'b1, 1'b0);
    checkOutput("restart_next_result", int'(result8), 3);
    checkOutput("restart_next_out", int'(out8), 1);

    @(negedge clk);
    in_valid = 1'b0;
    #1 clr_n = 1'b0;
    #1;
    checkOutput("async_out", int'(out8), 0);
    checkOutput("async_result", int'(result8), 0);
    #1 clr_n = 1'b1;
    applyStimulus("4", 1'b1, 1'b0);
    checkOutput("post_reset_result", int'(result8), 4);
    checkOutput("post_reset_out", int'(out8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
